conv3x3_tile_acc: RTL and testbench

Parametrised 3x3 convolution engine: each accepted beat computes an OUT_ROWS x OUT_COLS tile of 9-tap dot products from a (OUT_ROWS+2) x (OUT_COLS+2) activation window and one 3x3 weight set. It then accumulates the tile across input channels, with optional bias, signed/unsigned activations and saturating accumulation. It sits between the line-buffer/window fetcher and the requantiser in the conv datapath. It is the multi-channel, size-generic successor of the fixed 2x2-tile MAC.

---
 rtl/conv_mac_pkg.sv | 16 +
 rtl/tap9_dot_pipe.sv | 24 ++
 rtl/conv3x3_tile_acc.sv | 113 +++++++++++
 tb/tb_conv3x3_tile_acc.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_mac_pkg.sv
// conv_mac_pkg: shared constants, window indexing and saturation helpers for the 3x3 conv MAC
package conv_mac_pkg;
  localparam int KSIZE = 3;
  localparam int KTAPS = 9;
  typedef enum logic {IDLE, ACC} seq_state_t;
  function automatic int tap_idx(input int r, input int c, input int kr, input int kc, input int out_cols);
    return (r + kr) * (out_cols + 2) + c + kc;
  endfunction
  function automatic logic signed [63:0] sat_clamp(input logic signed [63:0] value, input int acc_w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (acc_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (acc_w - 1));
    return value > hi ? hi : value < lo ? lo : value;
  endfunction
endpackage

// File: rtl/tap9_dot_pipe.sv
// tap9_dot_pipe: one output pixel, 9 registered products then a 3+1 adder tree (three stages)
module tap9_dot_pipe import conv_mac_pkg::*; #(
  parameter int DW = 8,
  parameter int WW = 8
) (
  input  logic                      clk,
  input  logic                      act_signed,
  input  logic [KTAPS*DW-1:0]       din,
  input  logic [KTAPS*WW-1:0]       weight,
  output logic signed [DW+WW+4:0]   sum
);
  localparam int PW = DW + WW + 1;
  localparam int TW = DW + WW + 3;
  localparam int SW = DW + WW + 5;
  logic signed [PW-1:0] prod [KTAPS];
  logic signed [TW-1:0] part [KSIZE];
  always_ff @(posedge clk) begin
    for (int t = 0; t < KTAPS; t++)
      prod[t] <= PW'($signed({act_signed & din[t*DW+DW-1], din[t*DW +: DW]})) * PW'($signed(weight[t*WW +: WW]));
    for (int k = 0; k < KSIZE; k++)
      part[k] <= TW'(prod[3*k]) + TW'(prod[3*k+1]) + TW'(prod[3*k+2]);
    sum <= SW'(part[0]) + SW'(part[1]) + SW'(part[2]);
  end
endmodule

// File: rtl/conv3x3_tile_acc.sv
// conv3x3_tile_acc: 3x3 conv tile engine accumulating OUT_ROWS x OUT_COLS pixels across input channels
// with first/last sequencing, bias on the first beat and saturating accumulation.
module conv3x3_tile_acc import conv_mac_pkg::*; #(
  parameter int DW = 8,
  parameter int WW = 8,
  parameter int OUT_ROWS = 2,
  parameter int OUT_COLS = 2,
  parameter int ACC_W = 24,
  localparam int NPIX = OUT_ROWS * OUT_COLS,
  localparam int NIN = (OUT_ROWS + 2) * (OUT_COLS + 2)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  i_vld,
  input  logic                  i_first,
  input  logic                  i_last,
  input  logic                  i_act_signed,
  input  logic [NIN*DW-1:0]     i_din,
  input  logic [KTAPS*WW-1:0]   i_weight,
  input  logic [ACC_W-1:0]      i_bias,
  output logic                  o_vld,
  output logic                  o_vld_prev,
  output logic [NPIX*ACC_W-1:0] o_acc,
  output logic [NPIX-1:0]       o_sat,
  output logic                  o_err_seq
);
  localparam int SW = DW + WW + 5;
  seq_state_t state, state_nxt;
  logic s0_vld, s0_first, s0_last, s0_sgn;
  logic [NIN*DW-1:0] s0_din;
  logic [KTAPS*WW-1:0] s0_w;
  logic signed [ACC_W-1:0] s0_bias, s1_bias, s2_bias, s3_bias;
  logic s1_acc, s1_load, s1_emit, s2_acc, s2_load, s2_emit, s3_acc, s3_load, s3_emit;
  logic accept, load, emit, err;
  logic signed [SW-1:0] sum [NPIX];
  logic signed [ACC_W-1:0] acc [NPIX];
  logic signed [ACC_W-1:0] acc_nxt [NPIX];
  logic signed [ACC_W:0] sum_w [NPIX];
  logic signed [63:0] full [NPIX];
  logic [NPIX-1:0] sat, hit;
  always_ff @(posedge clk) begin
    s0_first <= i_first;
    s0_last <= i_last;
    s0_sgn <= i_act_signed;
    s0_din <= i_din;
    s0_w <= i_weight;
    s0_bias <= $signed(i_bias);
    s1_bias <= s0_bias;
    s2_bias <= s1_bias;
    s3_bias <= s2_bias;
  end
  for (genvar p = 0; p < NPIX; p++) begin : g_pix
    logic [KTAPS*DW-1:0] win;
    for (genvar t = 0; t < KTAPS; t++) begin : g_tap
      assign win[t*DW +: DW] = s0_din[tap_idx(p / OUT_COLS, p % OUT_COLS, t / KSIZE, t % KSIZE, OUT_COLS)*DW +: DW];
    end
    tap9_dot_pipe #(.DW(DW), .WW(WW)) u_dot (
      .clk(clk),
      .act_signed(s0_sgn),
      .din(win),
      .weight(s0_w),
      .sum(sum[p])
    );
  end
  // A first beat always (re)starts a tile; a first seen mid-tile is flagged but still honoured.
  always_comb begin
    accept = s0_vld & (s0_first | state == ACC);
    load = s0_vld & s0_first;
    emit = accept & s0_last;
    err = s0_vld & (s0_first == (state == ACC));
    state_nxt = accept ? (s0_last ? IDLE : ACC) : state;
  end
  always_comb begin
    for (int p = 0; p < NPIX; p++) begin
      sum_w[p] = (ACC_W+1)'(s3_load ? s3_bias : acc[p]) + (ACC_W+1)'(sum[p]);
      full[p] = sat_clamp(64'(sum_w[p]), ACC_W);
      acc_nxt[p] = ACC_W'(full[p]);
      hit[p] = full[p] != 64'(sum_w[p]);
    end
  end
  assign o_vld_prev = s3_emit;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      s0_vld <= 1'b0;
      {s1_acc, s1_load, s1_emit} <= '0;
      {s2_acc, s2_load, s2_emit} <= '0;
      {s3_acc, s3_load, s3_emit} <= '0;
      o_err_seq <= 1'b0;
      o_vld <= 1'b0;
      o_acc <= '0;
      o_sat <= '0;
      sat <= '0;
      for (int p = 0; p < NPIX; p++) acc[p] <= '0;
    end else begin
      state <= state_nxt;
      s0_vld <= i_vld;
      o_err_seq <= err;
      {s1_acc, s1_load, s1_emit} <= {accept, load, emit};
      {s2_acc, s2_load, s2_emit} <= {s1_acc, s1_load, s1_emit};
      {s3_acc, s3_load, s3_emit} <= {s2_acc, s2_load, s2_emit};
      o_vld <= s3_emit;
      if (s3_acc) begin
        for (int p = 0; p < NPIX; p++) acc[p] <= acc_nxt[p];
        sat <= (s3_load ? '0 : sat) | hit;
      end
      if (s3_emit) begin
        for (int p = 0; p < NPIX; p++) o_acc[p*ACC_W +: ACC_W] <= acc_nxt[p];
        o_sat <= (s3_load ? '0 : sat) | hit;
      end
    end
  end
endmodule

// File: tb/tb_conv3x3_tile_acc.sv
// tb_conv3x3_tile_acc: directed and random tiles checked against an arithmetic tile model
module tb_conv3x3_tile_acc;
  localparam int DW = 8, WW = 8, NPIX = 4, NIN = 16, ACC_W = 24;
  localparam longint AMAX = 8388607, AMIN = -8388608;
  logic clk = 0, rstn = 0;
  logic i_vld = 0, i_first = 0, i_last = 0, i_act_signed = 0;
  logic [NIN*DW-1:0] i_din = '0;
  logic [9*WW-1:0] i_weight = '0;
  logic [ACC_W-1:0] i_bias = '0;
  logic o_vld, o_vld_prev, o_err_seq;
  logic [NPIX*ACC_W-1:0] o_acc;
  logic [NPIX-1:0] o_sat;
  int total = 0, bad = 0;
  int din_a[NIN];
  int w_a[9];
  longint m_acc[NPIX];
  bit m_sat[NPIX];
  bit in_tile = 0;
  longint exp_q[$];
  logic [NPIX-1:0] sat_q[$];

  conv3x3_tile_acc #(.DW(DW), .WW(WW), .OUT_ROWS(2), .OUT_COLS(2), .ACC_W(ACC_W)) dut (
    .clk(clk), .rstn(rstn), .i_vld(i_vld), .i_first(i_first), .i_last(i_last),
    .i_act_signed(i_act_signed), .i_din(i_din), .i_weight(i_weight), .i_bias(i_bias),
    .o_vld(o_vld), .o_vld_prev(o_vld_prev), .o_acc(o_acc), .o_sat(o_sat), .o_err_seq(o_err_seq)
  );

  always #5 clk = ~clk;

  function automatic longint pix_sum(int r, int c, bit sg);
    longint s = 0;
    for (int kr = 0; kr < 3; kr++)
      for (int kc = 0; kc < 3; kc++) begin
        longint a = din_a[(r + kr) * 4 + c + kc];
        longint w = w_a[kr * 3 + kc];
        if (sg && a > 127) a -= 256;
        if (w > 127) w -= 256;
        s += a * w;
      end
    return s;
  endfunction

  task automatic set_all(int d, int w);
    for (int k = 0; k < NIN; k++) din_a[k] = d;
    for (int k = 0; k < 9; k++) w_a[k] = w;
  endtask

  task automatic beat(bit f, bit l, bit sg, int b);
    logic [NPIX-1:0] sb;
    @(negedge clk);
    i_vld = 1; i_first = f; i_last = l; i_act_signed = sg; i_bias = b[ACC_W-1:0];
    for (int k = 0; k < NIN; k++) i_din[k*DW +: DW] = din_a[k][7:0];
    for (int k = 0; k < 9; k++) i_weight[k*WW +: WW] = w_a[k][7:0];
    if (f || in_tile) begin
      for (int p = 0; p < NPIX; p++) begin
        longint v = (f ? longint'(b) : m_acc[p]) + pix_sum(p / 2, p % 2, sg);
        bit h = 0;
        if (v > AMAX) begin v = AMAX; h = 1; end
        if (v < AMIN) begin v = AMIN; h = 1; end
        m_acc[p] = v;
        m_sat[p] = (f ? 1'b0 : m_sat[p]) | h;
      end
      in_tile = !l;
      if (l) begin
        for (int p = 0; p < NPIX; p++) begin exp_q.push_back(m_acc[p]); sb[p] = m_sat[p]; end
        sat_q.push_back(sb);
      end
    end
    @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
    i_vld = 0; i_first = 0; i_last = 0;
  endtask

  task automatic wait_out(output int cyc);
    cyc = -1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (o_vld) begin cyc = k; break; end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    total += 3;
    if (o_vld !== 1'b0 || o_vld_prev !== 1'b0 || o_err_seq !== 1'b0) begin
      bad++; $display("FAIL reset_flags: got vld=%b prev=%b err=%b want 0", o_vld, o_vld_prev, o_err_seq);
    end
    if (o_acc !== '0) begin bad++; $display("FAIL reset_acc: got %h want 0", o_acc); end
    if (o_sat !== '0) begin bad++; $display("FAIL reset_sat: got %b want 0", o_sat); end
    rstn = 1;
    @(negedge clk);
    total++;
    if (o_vld !== 1'b0) begin bad++; $display("FAIL reset_release_vld: got %b want 0", o_vld); end
  endtask

  task automatic test_single();
    set_all(1, 1);
    beat(1, 1, 0, 0);
    idle();
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      total += 2;
      if (o_vld_prev !== (k == 3)) begin bad++; $display("FAIL single_prev@T+%0d: got %b want %b", k, o_vld_prev, k == 3); end
      if (o_vld !== (k == 4)) begin bad++; $display("FAIL single_vld@T+%0d: got %b want %b", k, o_vld, k == 4); end
    end
    for (int p = 0; p < NPIX; p++) begin
      longint e = exp_q.pop_front();
      longint g = longint'($signed(o_acc[p*ACC_W +: ACC_W]));
      total++;
      if (g !== e || g !== 9) begin bad++; $display("FAIL single_acc[%0d]: got %0d want %0d", p, g, e); end
    end
    total++;
    if (o_sat !== sat_q.pop_front()) begin bad++; $display("FAIL single_sat: got %b want 0000", o_sat); end
  endtask

  task automatic test_extremes();
    int cyc;
    for (int s = 1; s >= 0; s--) begin
      set_all(128, 127);
      beat(1, 1, s[0], 100);
      idle();
      wait_out(cyc);
      total++;
      if (cyc != 4) begin bad++; $display("FAIL extreme_latency s=%0d: got %0d want 4", s, cyc); end
      for (int p = 0; p < NPIX; p++) begin
        longint e = exp_q.pop_front();
        longint g = longint'($signed(o_acc[p*ACC_W +: ACC_W]));
        total++;
        if (g !== e) begin bad++; $display("FAIL extreme_acc s=%0d [%0d]: got %0d want %0d", s, p, g, e); end
      end
      total++;
      if (longint'($signed(o_acc[ACC_W-1:0])) !== (s ? -146204 : 146404)) begin
        bad++; $display("FAIL extreme_const s=%0d: got %0d", s, $signed(o_acc[ACC_W-1:0]));
      end
      void'(sat_q.pop_front());
    end
  endtask

  task automatic test_back_to_back();
    int first_k = -1, pulses = 0;
    set_all(1, 1); beat(1, 0, 0, 0);
    set_all(2, 1); beat(0, 0, 0, 0);
    set_all(3, 1); beat(0, 1, 0, 0);
    idle();
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (o_vld) begin pulses++; if (first_k < 0) first_k = k; end
    end
    total += 2;
    if (pulses != 1) begin bad++; $display("FAIL b2b_pulses: got %0d want 1", pulses); end
    if (first_k + 2 != 6) begin bad++; $display("FAIL b2b_latency: got T0+%0d want T0+6", first_k + 2); end
    for (int p = 0; p < NPIX; p++) begin
      longint e = exp_q.pop_front();
      longint g = longint'($signed(o_acc[p*ACC_W +: ACC_W]));
      total++;
      if (g !== e || g !== 54) begin bad++; $display("FAIL b2b_acc[%0d]: got %0d want %0d", p, g, e); end
    end
    void'(sat_q.pop_front());
    set_all(1, 1); beat(1, 1, 0, 5);
    set_all(2, 3); beat(1, 1, 0, -7);
    idle();
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k >= 3) begin
        total++;
        if (o_vld !== 1'b1) begin bad++; $display("FAIL tile_b2b_vld@%0d: got %b want 1", k, o_vld); end
        for (int p = 0; p < NPIX; p++) begin
          longint e = exp_q.pop_front();
          longint g = longint'($signed(o_acc[p*ACC_W +: ACC_W]));
          total++;
          if (g !== e) begin bad++; $display("FAIL tile_b2b_acc@%0d[%0d]: got %0d want %0d", k, p, g, e); end
        end
        void'(sat_q.pop_front());
      end
    end
  endtask

  task automatic test_sat();
    int cyc;
    set_all(255, 127);
    beat(1, 1, 0, 8388000);
    idle();
    wait_out(cyc);
    for (int p = 0; p < NPIX; p++) begin
      longint e = exp_q.pop_front();
      longint g = longint'($signed(o_acc[p*ACC_W +: ACC_W]));
      total++;
      if (g !== e || g !== AMAX) begin bad++; $display("FAIL sat_acc[%0d]: got %0d want %0d", p, g, e); end
    end
    total++;
    if (o_sat !== sat_q.pop_front() || o_sat !== 4'hF) begin bad++; $display("FAIL sat_flags: got %b want 1111", o_sat); end
    set_all(1, 1);
    beat(1, 1, 0, 3);
    idle();
    wait_out(cyc);
    for (int p = 0; p < NPIX; p++) begin
      longint e = exp_q.pop_front();
      longint g = longint'($signed(o_acc[p*ACC_W +: ACC_W]));
      total++;
      if (g !== e) begin bad++; $display("FAIL sat_next_acc[%0d]: got %0d want %0d", p, g, e); end
    end
    total++;
    if (o_sat !== sat_q.pop_front()) begin bad++; $display("FAIL sat_clear: got %b want 0000", o_sat); end
  endtask

  task automatic test_seq();
    int cyc, pulses = 0;
    set_all(5, 3);
    beat(0, 1, 1, 0);
    idle();
    @(negedge clk);
    total++;
    if (o_err_seq !== 1'b1) begin bad++; $display("FAIL seq_idle_err: got %b want 1", o_err_seq); end
    @(negedge clk);
    total++;
    if (o_err_seq !== 1'b0) begin bad++; $display("FAIL seq_err_width: got %b want 0", o_err_seq); end
    for (int k = 0; k < 7; k++) begin @(negedge clk); if (o_vld) pulses++; end
    total++;
    if (pulses != 0) begin bad++; $display("FAIL seq_drop_vld: got %0d pulses want 0", pulses); end
    set_all(7, 2); beat(1, 0, 1, 50);
    set_all(3, 255); beat(1, 1, 1, -20);
    idle();
    @(negedge clk);
    total++;
    if (o_err_seq !== 1'b1) begin bad++; $display("FAIL seq_restart_err: got %b want 1", o_err_seq); end
    wait_out(cyc);
    total++;
    if (cyc != 3) begin bad++; $display("FAIL seq_restart_latency: got %0d want 3", cyc); end
    for (int p = 0; p < NPIX; p++) begin
      longint e = exp_q.pop_front();
      longint g = longint'($signed(o_acc[p*ACC_W +: ACC_W]));
      total++;
      if (g !== e) begin bad++; $display("FAIL seq_restart_acc[%0d]: got %0d want %0d", p, g, e); end
    end
    void'(sat_q.pop_front());
  endtask

  task automatic test_reset_mid();
    int cyc, pulses = 0;
    set_all(4, 4);
    beat(1, 1, 0, 0);
    idle();
    @(negedge clk);
    @(posedge clk);
    #1 rstn = 0;
    in_tile = 0;
    exp_q.delete();
    sat_q.delete();
    @(negedge clk);
    rstn = 1;
    for (int k = 0; k < 8; k++) begin @(negedge clk); if (o_vld) pulses++; end
    total += 2;
    if (pulses != 0) begin bad++; $display("FAIL rstmid_vld: got %0d pulses want 0", pulses); end
    if (o_acc !== '0) begin bad++; $display("FAIL rstmid_acc: got %h want 0", o_acc); end
    set_all(2, 5);
    beat(1, 1, 0, 11);
    idle();
    wait_out(cyc);
    for (int p = 0; p < NPIX; p++) begin
      longint e = exp_q.pop_front();
      longint g = longint'($signed(o_acc[p*ACC_W +: ACC_W]));
      total++;
      if (g !== e) begin bad++; $display("FAIL rstmid_next_acc[%0d]: got %0d want %0d", p, g, e); end
    end
    void'(sat_q.pop_front());
  endtask

  task automatic test_random();
    int cyc;
    for (int n = 0; n < 25; n++) begin
      int nb = $urandom_range(1, 3);
      bit sg = 1'($urandom_range(0, 1));
      int b = int'($urandom_range(0, 2097152)) - 1048576;
      for (int j = 0; j < nb; j++) begin
        for (int k = 0; k < NIN; k++) din_a[k] = $urandom_range(0, 255);
        for (int k = 0; k < 9; k++) w_a[k] = $urandom_range(0, 255);
        beat(j == 0, j == nb - 1, sg, b);
      end
      idle();
      wait_out(cyc);
      total++;
      if (cyc != 4) begin bad++; $display("FAIL rand%0d_latency: got %0d want 4", n, cyc); end
      for (int p = 0; p < NPIX; p++) begin
        longint e = exp_q.pop_front();
        longint g = longint'($signed(o_acc[p*ACC_W +: ACC_W]));
        total++;
        if (g !== e) begin bad++; $display("FAIL rand%0d_acc[%0d]: got %0d want %0d", n, p, g, e); end
      end
      total++;
      if (o_sat !== sat_q.pop_front()) begin bad++; $display("FAIL rand%0d_sat: got %b", n, o_sat); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_extremes();
    test_back_to_back();
    test_sat();
    test_seq();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
